dcache_wb: RTL

- Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and the DRAM controller.
- Consumes the CPU's word-granular `addr`/`wdata`/`read_enable`/`write_enable` and returns `rdata`/`miss`.
- Uses a 4-word (128-bit) line interface with req/ready handshake toward DRAM.
- The memory stage stalls the pipeline while `miss`=1.

---
 rtl/dcache_wb.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// A CPU word port sits on one side and a 128-bit line port toward DRAM on the other.
// Hits resolve combinationally in the request cycle. A miss optionally writes the
// dirty victim back, fills the line, and then spends one bubble cycle before the
// CPU's held request is retried as a hit.
module dcache_wb #(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    input  logic          read_enable,
    input  logic          write_enable,
    output logic [31:0]   rdata,
    output logic          miss,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned TAG_BITS = 28 - INDEX_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StWb, StFill, StUpdate} state_e;

    state_e state_q, state_d;

    // Data and tag arrays: read asynchronously, never reset.
    logic [127:0]          data_q [LINES];
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    // Valid and dirty bits: flops, cleared by reset.
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    // Index and tag of the missing request. Used for the fill so that a misbehaving
    // CPU cannot redirect the fill onto another line.
    logic [INDEX_BITS-1:0] lat_idx_q;
    logic [TAG_BITS-1:0]   lat_tag_q;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [127:0]          mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word;
    logic                  req;
    logic                  hit;
    logic                  store_hit;
    logic                  fill_en;
    logic                  unused_addr_bits;

    assign idx              = addr[INDEX_BITS+3:4];
    assign tag              = addr[31:INDEX_BITS+4];
    assign word             = addr[3:2];
    assign unused_addr_bits = ^addr[1:0];

    assign req       = read_enable | write_enable;
    assign hit       = (state_q == StIdle) && req && valid_q[idx] && (tag_q[idx] == tag);
    assign miss      = req && !hit;
    // A simultaneous read and write counts as a write.
    assign store_hit = hit && write_enable;
    assign rdata     = hit ? data_q[idx][{word, 5'b0} +: 32] : 32'h0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state logic and registered DRAM request fields. The request fields
    // change only on state entry, so they stay stable through the handshake.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    mem_req_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = StWb;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx, 4'b0};
                        mem_wdata_d = data_q[idx];
                    end else begin
                        state_d     = StFill;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {tag, idx, 4'b0};
                        mem_wdata_d = '0;
                    end
                end
            end
            StWb: begin
                if (mem_ready) begin
                    state_d     = StFill;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {lat_tag_q, lat_idx_q, 4'b0};
                    mem_wdata_d = '0;
                end
            end
            StFill: begin
                if (mem_ready) begin
                    state_d     = StUpdate;
                    fill_en     = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            StUpdate: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched miss address and DRAM request registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            lat_idx_q   <= '0;
            lat_tag_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (state_q == StIdle && miss) begin
                lat_idx_q <= idx;
                lat_tag_q <= tag;
            end
        end
    end

    // Valid/dirty bookkeeping: a fill installs a clean line; a store hit marks it dirty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[lat_idx_q] <= 1'b1;
            dirty_q[lat_idx_q] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Data/tag array writes. Fill and store hit never coincide (fill happens outside StIdle).
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[lat_idx_q] <= mem_rdata;
            tag_q[lat_idx_q]  <= lat_tag_q;
        end else if (store_hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= wdata;
        end
    end

endmodule
